// File: rtl/ram_scan_pkg.sv
// Shared types and default sizing for the RAM scan reader.
package ram_scan_pkg;

  localparam int RAM_ADDR_W = 5;
  localparam int RAM_DATA_W = 4;
  localparam int CLK_HZ     = 50_000_000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_SHOW = 2'd2
  } scan_state_e;

endpackage

// File: rtl/ram_scan_reader_dwell_timer.sv
// Dwell timer: up-counter with synchronous clear; expire flags the last
// clock of the dwell window while counting is enabled.
module dwell_timer #(
  parameter int DWELL = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int               CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: clear wins, otherwise count while enabled and roll at LAST.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign expire = en && (count_q == LAST);

endmodule

// File: rtl/ram_scan_reader.sv
// Read-side scanner for the switch-written RAM. Steps the read address
// automatically or on command, waits out the RAM read latency and presents
// a registered address/data pair to the display logic.
//
//   state  | meaning
//   S_IDLE | after reset, nothing shown yet; waits for enable/step/restart
//   S_READ | rd_addr updated, waiting READ_LAT clocks for rd_data
//   S_SHOW | word captured and shown; tracking live RAM data, dwell running
module ram_scan_reader
  import ram_scan_pkg::*;
#(
  parameter int ADDR_W   = RAM_ADDR_W,
  parameter int DATA_W   = RAM_DATA_W,
  parameter int READ_LAT = 1,
  parameter int DWELL    = CLK_HZ
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              step,
  input  logic              restart,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              wrap
);

  localparam int              LAT_W    = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LAT - 1);

  scan_state_e       state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic              disp_valid_q, disp_valid_d;
  logic              wrap_q, wrap_d;

  logic dwell_clear;
  logic dwell_en;
  logic dwell_expire;

  // Dwell only runs while a word is on show and auto mode is on.
  assign dwell_en = (state_q == S_SHOW) && enable;

  dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk    (clk),
    .reset  (reset),
    .clear  (dwell_clear),
    .en     (dwell_en),
    .expire (dwell_expire)
  );

  // Next-state, address, capture and wrap decisions.
  // Priority inside S_SHOW: restart, then step or dwell expiry (one increment).
  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    lat_d        = lat_q;
    disp_addr_d  = disp_addr_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = disp_valid_q;
    wrap_d       = 1'b0;
    dwell_clear  = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (enable || step || restart) begin
          state_d   = S_READ;
          rd_addr_d = '0;
          lat_d     = '0;
        end
      end

      S_READ: begin
        if (restart) begin
          rd_addr_d = '0;
          lat_d     = '0;
        end else if (lat_q == LAT_LAST) begin
          disp_data_d  = rd_data;
          disp_addr_d  = rd_addr_q;
          disp_valid_d = 1'b1;
          state_d      = S_SHOW;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end

      S_SHOW: begin
        // rd_data still reflects the shown address here, so live RAM
        // writes follow through to the display.
        disp_data_d = rd_data;
        dwell_clear = 1'b0;
        if (restart) begin
          rd_addr_d   = '0;
          lat_d       = '0;
          state_d     = S_READ;
          dwell_clear = 1'b1;
        end else if (step || dwell_expire) begin
          rd_addr_d   = rd_addr_q + ADDR_W'(1);
          wrap_d      = (rd_addr_q == {ADDR_W{1'b1}});
          lat_d       = '0;
          state_d     = S_READ;
          dwell_clear = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      rd_addr_q    <= '0;
      lat_q        <= '0;
      disp_addr_q  <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      lat_q        <= lat_d;
      disp_addr_q  <= disp_addr_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      wrap_q       <= wrap_d;
    end
  end

  assign rd_addr    = rd_addr_q;
  assign disp_addr  = disp_addr_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign wrap       = wrap_q;

endmodule
